// File: rtl/pipelined_ks_addsub.sv
// Parametrised Kogge-Stone adder/subtractor with optional register stages after the
// GP generation and after every prefix level. A single global stall freezes the whole
// pipeline when the output holds a result the consumer has not taken.
module pipelined_ks_addsub #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          PIPELINED = 1'b1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L = $clog2(WIDTH);

  // Everything that has to travel alongside one operation through the prefix tree.
  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             c0;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
  } stage_t;

  // One Kogge-Stone level at distance 2^k; bits below the distance pass through.
  function automatic stage_t prefix_level(input stage_t s, input int k);
    stage_t o;
    int     d;
    o = s;
    d = 32'sd1 << k;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i >= d) begin
        o.g[i] = s.g[i] | (s.p[i] & s.g[i-d]);
        o.p[i] = s.p[i] & s.p[i-d];
      end
    end
    return o;
  endfunction

  logic             w_stall;
  logic [WIDTH-1:0] w_yp;
  logic             w_c0;
  stage_t           w_in;
  stage_t           w_last;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [TAG_W-1:0] r_tag;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Operand conditioning: subtraction is X + ~Y + 1, carry-in ignored.
  assign w_yp = in_sub ? ~in_y : in_y;
  assign w_c0 = in_sub | in_cin;

  // Generate/propagate for the incoming operation.
  always_comb begin
    w_in     = '0;
    w_in.vld = in_valid & in_ready;
    w_in.tag = in_tag;
    w_in.c0  = w_c0;
    w_in.p0  = in_x ^ w_yp;
    w_in.p   = in_x ^ w_yp;
    w_in.g   = in_x & w_yp;
  end

  if (PIPELINED) begin : g_pipe
    // r_stg[0] holds GP; r_stg[k+1] holds the result of prefix level k.
    stage_t r_stg [0:L];

    // Whole pipeline advances together or freezes together; bubbles are kept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= L; k++) begin
          r_stg[k] <= '0;
        end
      end else if (!w_stall) begin
        r_stg[0] <= w_in;
        for (int k = 0; k < L; k++) begin
          r_stg[k+1] <= prefix_level(r_stg[k], k);
        end
      end
    end

    assign w_last = r_stg[L];
  end else begin : g_comb
    // Full prefix tree evaluated in one cycle ahead of the output register.
    always_comb begin
      stage_t v;
      v = w_in;
      for (int k = 0; k < L; k++) begin
        v = prefix_level(v, k);
      end
      w_last = v;
    end
  end

  // Carries from the group terms: c_i = G[i-1] | (P[i-1] & c0).
  always_comb begin
    w_carry    = '0;
    w_carry[0] = w_last.c0;
    for (int i = 1; i <= int'(WIDTH); i++) begin
      w_carry[i] = w_last.g[i-1] | (w_last.p[i-1] & w_last.c0);
    end
  end

  assign w_sum  = w_last.p0 ^ w_carry[WIDTH-1:0];
  assign w_cout = w_carry[WIDTH];
  assign w_ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];

  // Output register; holds its result while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_tag       <= '0;
    end else if (!w_stall) begin
      r_out_valid <= w_last.vld;
      r_sum       <= w_sum;
      r_cout      <= w_cout;
      r_ovf       <= w_ovf;
      r_tag       <= w_last.tag;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign out_tag   = r_tag;

endmodule
